// File: rtl/mem_read_controller.sv
// Load path of the datapath memory interface: issues a req/ack read, extracts the
// byte/halfword/word lane, extends it and flags misaligned, invalid or timed-out loads.
module mem_read_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  signed_load,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           readData,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    sgn_q, sgn_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    illegal;
  logic [7:0]              lane_b;
  logic [15:0]             lane_h;
  logic [31:0]             load_val;

  // Alignment / encoding check on the incoming command.
  always_comb begin
    illegal = 1'b0;
    case (size)
      SZ_HALF: illegal = addr[0];
      SZ_WORD: illegal = (addr[1:0] != 2'b00);
      SZ_BAD:  illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Lane select and sign/zero extension from the latched command.
  always_comb begin
    lane_b   = mem_rdata[{off_q, 3'b000} +: 8];
    lane_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (illegal) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_REQ;
            off_d      = addr[1:0];
            size_d     = size;
            sgn_d      = signed_load;
            mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end
      S_REQ: begin
        // An ack on the last allowed cycle still completes the load.
        if (mem_ack) begin
          state_d = S_DONE;
          rdata_d = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    error_d   = (state_d == S_ERR);
    mem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign readData = rdata_q;

endmodule
